// File: rtl/uart_packet_forwarder.sv
// Packet forwarder: serialises a PKT_BYTES packet into a byte-wide UART transmitter and
// optionally gathers a RSP_BYTES reply under an inter-byte timeout, resending on silence.
module uart_packet_forwarder #(
    parameter int PKT_BYTES   = 18,
    parameter int RSP_BYTES   = 4,
    parameter int TIMEOUT     = 4000000,
    parameter int MAX_RETRIES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pkt_valid,
    output logic                   pkt_ready,
    input  logic [PKT_BYTES*8-1:0] pkt_data,
    input  logic                   expect_rsp,
    output logic                   tx_start,
    output logic [7:0]             tx_byte,
    input  logic                   tx_done,
    input  logic                   tx_active,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_byte,
    output logic                   rsp_valid,
    output logic [RSP_BYTES*8-1:0] rsp_data,
    output logic                   done,
    output logic                   err_timeout,
    output logic                   busy,
    output logic [7:0]             retry_count
);

    localparam int IDX_W  = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
    localparam int RIDX_W = (RSP_BYTES > 1) ? $clog2(RSP_BYTES) : 1;
    localparam int CNT_W  = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(PKT_BYTES - 1);
    localparam logic [RIDX_W-1:0] LAST_RIDX   = RIDX_W'(RSP_BYTES - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT    = CNT_W'(TIMEOUT - 1);
    localparam logic [7:0]        RETRY_LIMIT = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, RSP_WAIT, FINISH} state_t;

    state_t                 state_reg, state_next;
    logic [PKT_BYTES*8-1:0] pkt_reg, pkt_next;
    logic                   expect_reg, expect_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic [RIDX_W-1:0]      ridx_reg, ridx_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [7:0]             retry_reg, retry_next;
    logic [RSP_BYTES*8-1:0] rsp_reg, rsp_next;
    logic [7:0]             tx_byte_reg, tx_byte_next;
    logic                   tx_start_reg, tx_start_next;
    logic                   ok_reg, ok_next;
    logic                   err_reg, err_next;
    logic [7:0]             pkt_bytes [PKT_BYTES];

    generate
        for (genvar gi = 0; gi < PKT_BYTES; gi++) begin : g_pkt_bytes
            assign pkt_bytes[gi] = pkt_reg[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            pkt_reg      <= '0;
            expect_reg   <= 1'b0;
            idx_reg      <= '0;
            ridx_reg     <= '0;
            cnt_reg      <= '0;
            retry_reg    <= '0;
            rsp_reg      <= '0;
            tx_byte_reg  <= '0;
            tx_start_reg <= 1'b0;
            ok_reg       <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pkt_reg      <= pkt_next;
            expect_reg   <= expect_next;
            idx_reg      <= idx_next;
            ridx_reg     <= ridx_next;
            cnt_reg      <= cnt_next;
            retry_reg    <= retry_next;
            rsp_reg      <= rsp_next;
            tx_byte_reg  <= tx_byte_next;
            tx_start_reg <= tx_start_next;
            ok_reg       <= ok_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pkt_next      = pkt_reg;
        expect_next   = expect_reg;
        idx_next      = idx_reg;
        ridx_next     = ridx_reg;
        cnt_next      = cnt_reg;
        retry_next    = retry_reg;
        rsp_next      = rsp_reg;
        tx_byte_next  = tx_byte_reg;
        tx_start_next = 1'b0;
        ok_next       = ok_reg;
        err_next      = err_reg;

        case (state_reg)
            IDLE: begin
                if (pkt_valid) begin
                    pkt_next    = pkt_data;
                    expect_next = expect_rsp;
                    idx_next    = '0;
                    ridx_next   = '0;
                    cnt_next    = '0;
                    retry_next  = '0;
                    rsp_next    = '0;
                    ok_next     = 1'b0;
                    err_next    = 1'b0;
                    state_next  = SEND;
                end
            end
            SEND: begin
                // The transmitter may still be shifting out a previous frame.
                if (!tx_active) begin
                    tx_byte_next  = pkt_bytes[idx_reg];
                    tx_start_next = 1'b1;
                    state_next    = WAIT_TX;
                end
            end
            WAIT_TX: begin
                if (tx_done) begin
                    if (idx_reg == LAST_IDX) begin
                        if (expect_reg) begin
                            cnt_next   = '0;
                            ridx_next  = '0;
                            state_next = RSP_WAIT;
                        end else begin
                            state_next = FINISH;
                        end
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = SEND;
                    end
                end
            end
            RSP_WAIT: begin
                // A byte arriving on the terminal-count cycle takes priority over the timeout.
                if (rx_valid) begin
                    cnt_next = '0;
                    for (int i = 0; i < RSP_BYTES; i++) begin
                        if (ridx_reg == RIDX_W'(i)) begin
                            rsp_next[i*8 +: 8] = rx_byte;
                        end
                    end
                    if (ridx_reg == LAST_RIDX) begin
                        ok_next    = 1'b1;
                        state_next = FINISH;
                    end else begin
                        ridx_next = ridx_reg + 1'b1;
                    end
                end else if (cnt_reg == LAST_CNT) begin
                    if (retry_reg < RETRY_LIMIT) begin
                        retry_next = retry_reg + 1'b1;
                        idx_next   = '0;
                        ridx_next  = '0;
                        rsp_next   = '0;
                        cnt_next   = '0;
                        state_next = SEND;
                    end else begin
                        err_next   = 1'b1;
                        state_next = FINISH;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            FINISH: begin
                ok_next    = 1'b0;
                err_next   = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign pkt_ready   = (state_reg == IDLE);
    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == FINISH);
    assign rsp_valid   = done & ok_reg;
    assign err_timeout = done & err_reg;
    assign tx_start    = tx_start_reg;
    assign tx_byte     = tx_byte_reg;
    assign rsp_data    = rsp_reg;
    assign retry_count = retry_reg;

endmodule
